sha256_round_ctrl: RTL

//  Sequences one SHA-256 compression per 512-bit block on the shared 8-word round unit.
//  - Buffers 16 message words (valid/ready) and expands the message schedule W[0..63].
//  - Supplies K[t], arms the round unit, captures its state after round 63 and accumulates H += state.
//  - Sits between the bus-side message FIFO and the round unit; multi-block messages chain through H.

---
 rtl/sha256_pkg.sv | 62 ++++++
 rtl/sha256_msg_sched.sv | 53 +++++
 rtl/sha256_round_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg
//   Shared constants and helpers for the SHA-256 round controller.
//   - K[0:63]  : per-round additive constants.
//   - IV[0:7]  : initial hash value H0..H7.
//   - rotr/s0/s1 : rotate and the two message-schedule sigma functions.
//   - state_t  : controller FSM states.
package sha256_pkg;

    localparam int WORD_W     = 32;
    localparam int NUM_ROUNDS = 64;
    localparam int MSG_WORDS  = 16;
    localparam int HASH_WORDS = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        WAIT,
        ROUND,
        FINAL,
        DONE
    } state_t;

    localparam logic [WORD_W-1:0] K [0:NUM_ROUNDS-1] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [WORD_W-1:0] IV [0:HASH_WORDS-1] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    // Small sigma 0 of the message schedule.
    function automatic logic [WORD_W-1:0] s0(input logic [WORD_W-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    // Small sigma 1 of the message schedule.
    function automatic logic [WORD_W-1:0] s1(input logic [WORD_W-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched
//   16-entry message-schedule window. Entry 0 always holds the word for the
//   current round; entry j holds W[t+j].
//   Ports:
//     clk, rst   : clock, async active-high reset
//     load       : push load_data into entry 15 and move the window down
//     load_data  : message word (W[0] is loaded first)
//     shift      : advance one round, pushing the expanded word W[t+16]
//     w_out      : entry 0 (W[t])
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              shift,
    output logic [WORD_W-1:0] w_out
);

    logic [WORD_W-1:0] w_reg   [0:MSG_WORDS-1];
    logic [WORD_W-1:0] w_next  [0:MSG_WORDS-1];
    logic [WORD_W-1:0] expand_word;

    // With entry j = W[t+j], the word entering at the top is
    // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t].
    assign expand_word = s1(w_reg[14]) + w_reg[9] + s0(w_reg[1]) + w_reg[0];

    // Loading and shifting both move the window toward entry 0; they only
    // differ in what enters at entry 15.
    generate
        for (genvar gi = 0; gi < MSG_WORDS - 1; gi++) begin : g_window
            assign w_next[gi] = w_reg[gi + 1];
        end
    endgenerate

    assign w_next[MSG_WORDS-1] = load ? load_data : expand_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MSG_WORDS; i++) begin
                w_reg[i] <= '0;
            end
        end else if (load || shift) begin
            for (int i = 0; i < MSG_WORDS; i++) begin
                w_reg[i] <= w_next[i];
            end
        end
    end

    assign w_out = w_reg[0];

endmodule

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl
//   Sequences one SHA-256 compression per 512-bit block on an external
//   8-word round unit and accumulates the chaining value H.
//   Ports:
//     clk, rst      : clock, async active-high reset
//     init          : IDLE only, H <= IV and clear digest_valid
//     start         : IDLE only, begin one block
//     msg_data/msg_valid/msg_ready : 16 message words, W[0] first
//     busy          : high outside IDLE
//     done          : one-cycle pulse when H has been updated
//     digest        : {H0..H7}, H0 in the top word
//     digest_valid  : set with done, cleared by init, start or rst
//     ru_run        : one-cycle arm pulse to the round unit
//     ru_delay0     : round unit delay load value (ROUND_DELAY)
//     ru_state_in   : {a..h} initial state (= H)
//     ru_w, ru_k    : W[t], K[t] during ROUND, zero otherwise
//     ru_state_out  : {a..h} from the round unit
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int ROUND_DELAY = 1,
    parameter int DATA_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    input  logic                 start,
    input  logic [DATA_W-1:0]    msg_data,
    input  logic                 msg_valid,
    output logic                 msg_ready,
    output logic                 busy,
    output logic                 done,
    output logic [8*DATA_W-1:0]  digest,
    output logic                 digest_valid,
    output logic                 ru_run,
    output logic [7:0]           ru_delay0,
    output logic [8*DATA_W-1:0]  ru_state_in,
    output logic [DATA_W-1:0]    ru_w,
    output logic [DATA_W-1:0]    ru_k,
    input  logic [8*DATA_W-1:0]  ru_state_out
);

    state_t            state_reg;
    logic [5:0]        t_reg;
    logic [3:0]        word_cnt_reg;
    logic [7:0]        wait_cnt_reg;
    logic [DATA_W-1:0] h_reg      [0:HASH_WORDS-1];
    logic [DATA_W-1:0] state_word [0:HASH_WORDS-1];

    logic              sched_load;
    logic              sched_shift;
    logic [DATA_W-1:0] sched_w;

    // The schedule consumes a word exactly when the controller accepts it.
    assign sched_load  = (state_reg == LOAD) && msg_valid;
    assign sched_shift = (state_reg == ROUND);

    sha256_msg_sched u_msg_sched (
        .clk       (clk),
        .rst       (rst),
        .load      (sched_load),
        .load_data (msg_data),
        .shift     (sched_shift),
        .w_out     (sched_w)
    );

    // Pack/unpack between the flat 256-bit buses and per-word arrays.
    generate
        for (genvar gi = 0; gi < HASH_WORDS; gi++) begin : g_words
            assign digest[(HASH_WORDS-gi)*DATA_W-1 -: DATA_W]      = h_reg[gi];
            assign ru_state_in[(HASH_WORDS-gi)*DATA_W-1 -: DATA_W] = h_reg[gi];
            assign state_word[gi] = ru_state_out[(HASH_WORDS-gi)*DATA_W-1 -: DATA_W];
        end
    endgenerate

    assign ru_delay0 = 8'(ROUND_DELAY);
    assign ru_w      = (state_reg == ROUND) ? sched_w : '0;
    assign ru_k      = (state_reg == ROUND) ? K[t_reg] : '0;

    // Single FSM process; every output flag is set on the transition into
    // the state that owns it, so it is high for exactly that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            t_reg        <= '0;
            word_cnt_reg <= '0;
            wait_cnt_reg <= '0;
            msg_ready    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            digest_valid <= 1'b0;
            ru_run       <= 1'b0;
            for (int i = 0; i < HASH_WORDS; i++) begin
                h_reg[i] <= IV[i];
            end
        end else begin
            done   <= 1'b0;
            ru_run <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // init and start together: H is reloaded in this same
                    // edge, so the block begins from IV.
                    if (init) begin
                        digest_valid <= 1'b0;
                        for (int i = 0; i < HASH_WORDS; i++) begin
                            h_reg[i] <= IV[i];
                        end
                    end
                    if (start) begin
                        state_reg    <= LOAD;
                        msg_ready    <= 1'b1;
                        busy         <= 1'b1;
                        digest_valid <= 1'b0;
                        word_cnt_reg <= '0;
                    end
                end

                LOAD: begin
                    if (msg_valid) begin
                        word_cnt_reg <= word_cnt_reg + 4'd1;
                        if (word_cnt_reg == 4'(MSG_WORDS - 1)) begin
                            state_reg <= ARM;
                            msg_ready <= 1'b0;
                            ru_run    <= 1'b1;
                        end
                    end
                end

                ARM: begin
                    // Counts down to 0 so WAIT lasts ROUND_DELAY cycles.
                    state_reg    <= WAIT;
                    wait_cnt_reg <= 8'(ROUND_DELAY - 1);
                end

                WAIT: begin
                    if (wait_cnt_reg == 8'd0) begin
                        state_reg <= ROUND;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 8'd1;
                    end
                end

                ROUND: begin
                    // 6-bit counter wraps back to 0 on the last round.
                    t_reg <= t_reg + 6'd1;
                    if (t_reg == 6'(NUM_ROUNDS - 1)) begin
                        state_reg <= FINAL;
                    end
                end

                FINAL: begin
                    for (int i = 0; i < HASH_WORDS; i++) begin
                        h_reg[i] <= h_reg[i] + state_word[i];
                    end
                    state_reg    <= DONE;
                    done         <= 1'b1;
                    digest_valid <= 1'b1;
                end

                DONE: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end

                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    msg_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
